// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : huffman_pkg
// Description : Shared constants and helpers for the Huffman bit packer.
// Revision    : 1.0 - initial release
// ============================================================================
package huffman_pkg;

   localparam int WORD_W  = 32;  // width of an emitted packed word
   localparam int MAX_LEN = 8;   // longest code word accepted per cycle
   localparam int BUF_W   = 40;  // one word plus room for a full-length carry

   // Lengths above MAX_LEN are treated as MAX_LEN.
   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      return (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
   endfunction

   // Mask with the low 'len' bits set; 'len' is already clamped to 0..8.
   function automatic logic [MAX_LEN-1:0] code_mask(input logic [3:0] len);
      logic [MAX_LEN:0] m;
      m = (9'd1 << len) - 9'd1;
      return m[MAX_LEN-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_coder.sv
`default_nettype none
// ============================================================================
// Module      : huffman_coder
// Description : Packs 0..8-bit code words MSB-first into 32-bit words and
//               strobes each completed word for one cycle. No backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_coder
   import huffman_pkg::*;
(
   input  logic                clock,
   input  logic                resetn,       // active-high asynchronous reset
   input  logic [MAX_LEN-1:0]  code,
   input  logic [3:0]          length,
   output logic [WORD_W-1:0]   encoded_out,
   output logic                enable_out
);

   // Left-aligned accumulation buffer: oldest bit sits at the top.
   logic [BUF_W-1:0]   bit_buf;
   logic [5:0]         fill;

   logic [3:0]         eff_len;
   logic [MAX_LEN-1:0] new_bits;
   logic [5:0]         sum;
   logic [5:0]         shift;
   logic [BUF_W-1:0]   merged;
   logic               word_done;

   // Mask the incoming code and merge it just below the bits already held.
   always_comb begin
      eff_len   = clamp_len(length);
      new_bits  = code & code_mask(eff_len);
      sum       = fill + {2'b00, eff_len};
      // Lowest new bit lands at BUF_W - fill - L; always >= 1 since fill <= 31.
      shift     = 6'(BUF_W) - sum;
      merged    = bit_buf | ({{(BUF_W-MAX_LEN){1'b0}}, new_bits} << shift);
      word_done = (sum >= 6'(WORD_W));
   end

   // Register bank: emit the top word on completion and carry the remainder up.
   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         bit_buf     <= '0;
         fill        <= '0;
         encoded_out <= '0;
         enable_out  <= 1'b0;
      end else if (word_done) begin
         encoded_out <= merged[BUF_W-1 -: WORD_W];
         enable_out  <= 1'b1;
         bit_buf     <= merged << WORD_W;
         fill        <= sum - 6'(WORD_W);
      end else begin
         bit_buf     <= merged;
         fill        <= sum;
         enable_out  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_huffman_coder.sv
`default_nettype none
// ============================================================================
// Module      : tb_huffman_coder
// Description : Directed self-checking bench for huffman_coder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_coder;

   logic        clock;
   logic        resetn;
   logic [7:0]  code;
   logic [3:0]  length;
   logic [31:0] encoded_out;
   logic        enable_out;

   int checks = 0;
   int errors = 0;

   huffman_coder dut (
      .clock       (clock),
      .resetn      (resetn),
      .code        (code),
      .length      (length),
      .encoded_out (encoded_out),
      .enable_out  (enable_out)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one symbol, then check strobe and word just after the edge.
   task automatic step(input logic [7:0] c, input logic [3:0] l,
                       input logic exp_en, input logic [31:0] exp_word,
                       input string tag);
      code   = c;
      length = l;
      @(posedge clock);
      #1;
      chk({tag, "_en"},   {39'd0, enable_out}, {39'd0, exp_en});
      chk({tag, "_word"}, {8'd0, encoded_out}, {8'd0, exp_word});
   endtask

   // Asynchronous reset mid-cycle, held across one edge with a live symbol.
   task automatic do_reset(input string tag);
      code   = 8'hFF;
      length = 4'd8;
      #2 resetn = 1'b1;
      #1;
      chk({tag, "_async_word"}, {8'd0, encoded_out}, 40'd0);
      chk({tag, "_async_en"},   {39'd0, enable_out}, 40'd0);
      chk({tag, "_async_fill"}, {34'd0, dut.fill},   40'd0);
      @(posedge clock);
      #1;
      chk({tag, "_held_word"}, {8'd0, encoded_out}, 40'd0);
      chk({tag, "_held_fill"}, {34'd0, dut.fill},   40'd0);
      #2 resetn = 1'b0;
      length = 4'd0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn = 1'b1;
      code   = 8'h00;
      length = 4'd0;
      #8;
      chk("por_word", {8'd0, encoded_out}, 40'd0);
      chk("por_en",   {39'd0, enable_out}, 40'd0);
      #4 resetn = 1'b0;
      @(posedge clock);
      #1;
      step(8'h00, 4'd0, 1'b0, 32'h0, "idle0");
      step(8'h5A, 4'd0, 1'b0, 32'h0, "idle1");
      chk("idle_fill", {34'd0, dut.fill}, 40'd0);

      // Full bytes: one pulse after the 4th symbol, exact boundary.
      step(8'hFF, 4'd8, 1'b0, 32'h0, "ff1");
      step(8'hFF, 4'd8, 1'b0, 32'h0, "ff2");
      step(8'hFF, 4'd8, 1'b0, 32'h0, "ff3");
      step(8'hFF, 4'd8, 1'b1, 32'hFFFFFFFF, "ff4");
      chk("ff_fill", {34'd0, dut.fill}, 40'd0);
      chk("ff_buf",  dut.bit_buf, 40'd0);
      step(8'h00, 4'd0, 1'b0, 32'hFFFFFFFF, "ff_hold");

      // Masking: upper nibble must never reach the output.
      for (int i = 0; i < 7; i++)
         step(8'hF0, 4'd4, 1'b0, 32'hFFFFFFFF, "mask");
      step(8'hF0, 4'd4, 1'b1, 32'h00000000, "mask_last");

      // Asynchronous reset with a partial word in flight.
      step(8'hFF, 4'd8, 1'b0, 32'h0, "pre_rst1");
      step(8'hFF, 4'd8, 1'b0, 32'h0, "pre_rst2");
      do_reset("rst1");
      step(8'h00, 4'd0, 1'b0, 32'h0, "post_rst");
      chk("post_rst_fill", {34'd0, dut.fill}, 40'd0);

      // Odd length with carry: 11 x 101 = 33 bits.
      for (int i = 0; i < 10; i++)
         step(8'h05, 4'd3, 1'b0, 32'h0, "odd");
      step(8'h05, 4'd3, 1'b1, 32'hB6DB6DB6, "odd_last");
      chk("odd_fill",  {34'd0, dut.fill}, 40'd1);
      chk("odd_carry", {39'd0, dut.bit_buf[39]}, 40'd1);
      chk("odd_rest",  {1'b0, dut.bit_buf[38:0]}, 40'd0);

      // Clamp and idle: length 12 acts as 8; idles do not disturb packing.
      do_reset("rst2");
      step(8'hAA, 4'd12, 1'b0, 32'h0, "clamp1");
      step(8'h00, 4'd0,  1'b0, 32'h0, "clamp_idle1");
      step(8'hAA, 4'd12, 1'b0, 32'h0, "clamp2");
      step(8'h00, 4'd0,  1'b0, 32'h0, "clamp_idle2");
      step(8'h00, 4'd0,  1'b0, 32'h0, "clamp_idle3");
      step(8'hAA, 4'd12, 1'b0, 32'h0, "clamp3");
      step(8'h00, 4'd0,  1'b0, 32'h0, "clamp_idle4");
      step(8'hAA, 4'd15, 1'b1, 32'hAAAAAAAA, "clamp4");
      step(8'h00, 4'd0,  1'b0, 32'hAAAAAAAA, "clamp_hold");

      // Reset mid-word: old 24 bits discarded, next word is all zeros.
      step(8'hFF, 4'd8, 1'b0, 32'hAAAAAAAA, "mid1");
      step(8'hFF, 4'd8, 1'b0, 32'hAAAAAAAA, "mid2");
      step(8'hFF, 4'd8, 1'b0, 32'hAAAAAAAA, "mid3");
      do_reset("rst3");
      step(8'h00, 4'd8, 1'b0, 32'h0, "zero1");
      step(8'h00, 4'd8, 1'b0, 32'h0, "zero2");
      step(8'h00, 4'd8, 1'b0, 32'h0, "zero3");
      step(8'h00, 4'd8, 1'b1, 32'h0, "zero4");
      chk("zero_fill", {34'd0, dut.fill}, 40'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
